rr_count_arbiter: RTL and testbench
===================================

Name: rr_count_arbiter

Overview:
Round-robin arbiter that shares a single WIDTH-bit up-counter between N requesters using a req/gnt handshake. Only the current owner may increment or clear the counter. A grant is held until the owner drops its request or a hold limit expires. The block sits between the requester logic and the shared count register. It provides fair, bounded-latency access and reports counter wrap-around.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, width of shared counter
MAX_HOLD, 8, maximum consecutive grant cycles per ownership (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
req  input  N  per-requester access request, level
inc  input  N  per-requester increment strobe, honoured only for owner
clr  input  N  per-requester clear strobe, honoured only for owner
gnt  output  N  one-hot grant, registered
gnt_id  output  3  index of current/last owner, registered
busy  output  1  high while any gnt bit is high
count  output  WIDTH  shared counter value, registered
wrap  output  1  one-cycle pulse when count wraps max->0 via inc

Behaviour:
- Reset (async, rst=1): gnt=0, gnt_id=0, busy=0, count=0, wrap=0, hold counter=0, priority pointer=0, state=IDLE. Outputs stay at these values while rst is held.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, select the first set req bit scanning circularly from the pointer (pointer, pointer+1, ... mod N).
  - Next edge: gnt[sel]=1, gnt_id=sel, busy=1, hold=1, state=GRANT.
  - Request-to-grant latency is 1 clock from IDLE.
  - If req==0, remain in IDLE with all outputs stable.
- GRANT, each edge with owner o:
  - Counter action applies only if req[o]=1. If clr[o]=1, count=0 (clr beats inc). Else if inc[o]=1, count=count+1 mod 2^WIDTH.
  - wrap=1 for exactly the one cycle after the edge where count goes from 2^WIDTH-1 to 0 via inc; otherwise wrap=0. clr never raises wrap.
  - inc/clr from non-owners are ignored in all states.
  - Release occurs if req[o]=0, or if hold==MAX_HOLD. On release, the edge sets gnt=0, busy=0, pointer=(o+1) mod N, state=IDLE. gnt_id keeps o.
  - If not released, hold=hold+1 and gnt is unchanged.
- Hold limit:
  - gnt[o] is high for at most MAX_HOLD consecutive cycles.
  - Counter actions in the final granted cycle are honoured.
- Handoff:
  - Every release is followed by exactly one idle cycle (gnt=0) before the next grant.
  - A lone requester holding req is regranted after that one-cycle gap.
- Fairness: with all N requesting continuously, grants rotate o, o+1, ... Worst-case wait is (N-1)*(MAX_HOLD+1)+1 cycles.
- In IDLE, count holds its value and all inc/clr are ignored.
- Reset mid-GRANT: immediate async clear of all state. After rst falls, arbitration restarts from pointer 0.
- gnt is always one-hot or zero. busy equals OR of gnt.

Test Plan:
1. Reset/idle: assert rst mid-run, then release it with req=0 -> gnt=0, busy=0, count=0, wrap=0 and stable for 10 cycles.
2. Single owner: req=0001, inc[0]=1 for 5 granted cycles, then drop req[0] -> gnt=0001 one cycle after req; count=5; gnt=0000 the edge after req drops.
3. Clear priority and isolation: owner 1 with inc=1 and clr=1 together -> count=0. Requester 2 pulses inc while 1 owns -> count unchanged.
4. Wrap: preload count=254 via increments, owner issues 2 incs -> count 255 then 0, wrap high exactly one cycle. A clr at 255 gives count=0 with wrap=0.
5. Round-robin and hold limit: req=1111 held, MAX_HOLD=8 -> grant order 0,1,2,3,0; each gnt high exactly 8 cycles with a 1-cycle gap between grants.
6. Lone requester with timeout: req=0100 held for 30 cycles -> gnt=0100 for 8 cycles, 1 cycle off, repeated; gnt_id=2 throughout.

Source files
------------

// File: rtl/rr_count_arbiter.sv
// rtl/rr_count_arbiter.sv - round-robin arbiter guarding a shared WIDTH-bit up-counter
module rr_count_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     inc,
    input  logic [N-1:0]     clr,
    output logic [N-1:0]     gnt,
    output logic [2:0]       gnt_id,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    localparam int IW = $clog2(N);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [7:0]       r_hold;
    logic [N-1:0]     r_gnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic [IW-1:0]    w_sel;
    logic [IW-1:0]    w_cand;
    logic             w_found;
    logic             w_own_req;
    logic             w_own_inc;
    logic             w_own_clr;
    logic             w_release;
    logic [IW-1:0]    w_next_ptr;

    // Scan downward so the candidate closest to the pointer is written last and wins.
    always_comb begin
        w_sel   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % N);
            if (req[w_cand]) begin
                w_sel   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_own_req  = req[r_owner];
    assign w_own_inc  = inc[r_owner];
    assign w_own_clr  = clr[r_owner];
    assign w_release  = !w_own_req || (r_hold == 8'(MAX_HOLD));
    assign w_next_ptr = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt        <= '0;
                        r_gnt[w_sel] <= 1'b1;
                        r_owner      <= w_sel;
                        r_busy       <= 1'b1;
                        r_hold       <= 8'd1;
                        r_state      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Counter action is honoured even on the releasing edge.
                    if (w_own_req) begin
                        if (w_own_clr) begin
                            r_count <= '0;
                        end else if (w_own_inc) begin
                            r_count <= r_count + 1'b1;
                            r_wrap  <= &r_count;
                        end
                    end
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = 3'(r_owner);
    assign busy   = r_busy;
    assign count  = r_count;
    assign wrap   = r_wrap;
endmodule

// File: tb/tb_rr_count_arbiter.sv
// tb/tb_rr_count_arbiter.sv - directed self-checking bench for rr_count_arbiter
module tb_rr_count_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] inc = '0;
    logic [3:0] clr = '0;
    logic [3:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic [7:0] count;
    logic       wrap;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    rr_count_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .inc    (inc),
        .clr    (clr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .count  (count),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Owner 3 increments continuously until count reads 254, then everything is dropped.
    task automatic goto254();
        req = 4'b1000;
        inc = 4'b1000;
        clr = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if (count === 8'd254) break;
            tick();
        end
        chk("preload_254", count, 8'd254);
        req = 4'b0000;
        inc = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        chk("regrant_3", gnt, 4'b1000);
    endtask

    initial begin
        // 1: reset, mid-run async reset, idle stability
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", count, 8'd0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_gnt_id", gnt_id, 3'd0);
        req = 4'b0001;
        inc = 4'b0001;
        tick();
        tick();
        tick();
        chk("pre_rst_count", count, 8'd2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_gnt", gnt, 4'b0000);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_count", count, 8'd0);
        req = 4'b0000;
        inc = 4'b0000;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("idle_stable", {gnt, busy, count, wrap}, {4'b0000, 1'b0, 8'd0, 1'b0});
            tick();
        end

        // 2: single owner with five increments
        req = 4'b0001;
        inc = 4'b0001;
        tick();
        chk("single_gnt", gnt, 4'b0001);
        chk("single_busy", busy, 1'b1);
        chk("single_count0", count, 8'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("single_count5", count, 8'd5);
        chk("single_still_gnt", gnt, 4'b0001);
        req = 4'b0000;
        inc = 4'b0000;
        tick();
        chk("single_release", gnt, 4'b0000);
        chk("single_rel_busy", busy, 1'b0);
        chk("single_rel_id", gnt_id, 3'd0);
        chk("single_rel_count", count, 8'd5);

        // 3: clear beats increment, non-owner isolation
        req = 4'b0010;
        tick();
        chk("own1_gnt", gnt, 4'b0010);
        chk("own1_id", gnt_id, 3'd1);
        inc = 4'b0010;
        clr = 4'b0010;
        tick();
        chk("clr_beats_inc", count, 8'd0);
        clr = 4'b0000;
        tick();
        tick();
        chk("own1_inc2", count, 8'd2);
        inc = 4'b0100;
        tick();
        tick();
        chk("nonowner_inc", count, 8'd2);
        chk("nonowner_wrap", wrap, 1'b0);
        req = 4'b0000;
        inc = 4'b0000;
        tick();

        // 4: wrap pulse and clear at max
        goto254();
        inc = 4'b1000;
        tick();
        chk("count_255", count, 8'd255);
        chk("wrap_pre", wrap, 1'b0);
        tick();
        chk("count_wrapped", count, 8'd0);
        chk("wrap_pulse", wrap, 1'b1);
        inc = 4'b0000;
        tick();
        chk("wrap_one_cycle", wrap, 1'b0);
        chk("count_after_wrap", count, 8'd0);
        req = 4'b0000;
        tick();
        goto254();
        inc = 4'b1000;
        tick();
        chk("count_255_b", count, 8'd255);
        inc = 4'b0000;
        clr = 4'b1000;
        tick();
        chk("clr_at_max", count, 8'd0);
        chk("clr_no_wrap", wrap, 1'b0);
        clr = 4'b0000;
        req = 4'b0000;
        tick();

        // 5: full contention rotates 0,1,2,3,0 with 8-cycle holds and 1-cycle gaps
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (g % 4);
            for (int c = 0; c < 8; c++) begin
                chk("rr_gnt", gnt, exp_g);
                chk("rr_id", gnt_id, 3'(g % 4));
                tick();
            end
            chk("rr_gap", {gnt, busy}, {4'b0000, 1'b0});
            tick();
        end
        req = 4'b0000;
        tick();

        // 6: lone requester regranted after each timeout gap
        req = 4'b0100;
        tick();
        for (int i = 0; i < 30; i++) begin
            chk("lone_gnt", gnt, ((i % 9) < 8) ? 4'b0100 : 4'b0000);
            chk("lone_id", gnt_id, 3'd2);
            tick();
        end
        req = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
